sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
Upstream feeder for the Sobel edge stage. Converts the 24-bit RGB pixel stream to 8-bit grayscale and buffers two previous image rows. Emits a registered 3x3 grayscale neighbourhood per accepted pixel, so the Sobel stage sees full windows instead of a single previous pixel. Tracks column and row position and flags frame end.

Parameters:
IMG_W, 640, pixels per row (≥3)
IMG_H, 480, rows per frame (≥3)
PIX_W, 8, grayscale sample width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
pix_in  in  24  RGB pixel, R=[23:16], G=[15:8], B=[7:0]
pix_valid  in  1  pix_in valid this cycle; no backpressure
sof  in  1  start-of-frame marker
win_out  out  9*PIX_W  3x3 window; sample k at [PIX_W*k +: PIX_W], k=3*row+col, row0=top, col0=left, k=8 = newest pixel
win_valid  out  1  win_out holds a complete in-frame window
win_x  out  $clog2(IMG_W)  column of window centre
win_y  out  $clog2(IMG_H)  row of window centre
eof  out  1  one-cycle pulse after last pixel of frame

Behaviour:
- Reset (rst=0, async): col=0, row=0, window regs=0, win_out=0, win_valid=0, win_x=0, win_y=0, eof=0. Line-buffer RAM not cleared; contents are gated by win_valid.
- Gray conversion, combinational: sum = R + 2G + B (10 bits, no overflow), gray = sum[9:2].
- Accepted pixel = posedge with pix_valid=1 at position (c,r). All outputs are registered, with 1-cycle latency. Effects at t+1:
  - Shift window columns left; new right column = {lb1[c], lb0[c], gray} (top to bottom).
  - lb1[c] <= lb0[c]; lb0[c] <= gray. Read before write at the same address.
  - win_valid = (c≥2 && r≥2); win_x = c-1, win_y = r-1.
  - eof = (c==IMG_W-1 && r==IMG_H-1).
- Counters:
  - col increments per accepted pixel and wraps at IMG_W-1 to 0 with row++.
  - row wraps at IMG_H-1 to 0.
- pix_valid=0: window, counters and line buffers hold. win_valid=0 and eof=0 at t+1. win_out, win_x, win_y hold their values.
- sof=1 with pix_valid=1: that pixel is treated as (0,0), regardless of counters.
- sof=1 with pix_valid=0: col=row=0 at t+1; the next accepted pixel is (0,0).
- Windows never straddle rows. For c<2 the stale left columns exist, but win_valid=0.
- Reset mid-frame: the next accepted pixel after release is (0,0). The first valid window appears at the 2*IMG_W+3rd accepted pixel.
- No state machine beyond counters. The stage is fully pipelined at one pixel per clock.

Decomposition:
- Package sobel_pkg holds:
  - PIX_W default
  - RGB field index constants
  - function rgb2gray(24b)->PIX_W
  - window index localparams (K_TL=0 … K_BR=8)
- Sub-module line_buffer: IMG_W x PIX_W RAM, one address, read-before-write, write enable. Instantiated twice (lb0, lb1). Infers BRAM/LUTRAM, with no reset on the array.

Test Plan:
Bench uses IMG_W=4, IMG_H=4 unless noted.
1. Gray conversion:
   - pix_in=24'hFFFFFF → newest sample 8'hFF.
   - 24'h4080C0 → 8'h80.
   - 24'h000003 → 8'h00.
2. Ramp frame, gray value 16r+c per pixel (R=G=B):
   - First win_valid appears 1 cycle after the 11th pixel, with win_out k0..8 = 00,01,02,10,11,12,20,21,22 and win_x=1, win_y=1.
   - Exactly 4 valid windows per frame.
3. Same ramp with random pix_valid gaps:
   - Identical window sequence and coordinates.
   - win_valid never high on a cycle following an idle input cycle.
4. sof pulsed with the 6th pixel of a frame:
   - That pixel is (0,0).
   - The next win_valid follows the 10th subsequent pixel.
   - Window contents match the restarted ramp.
5. rst driven low between clock edges mid-frame:
   - win_out, win_valid and eof go to 0 immediately, without a clock edge.
   - After release, position restarts at (0,0).
6. Two back-to-back frames:
   - eof pulses for exactly 1 cycle after pixel (3,3).
   - No win_valid during rows 0–1 of frame 2.
   - Frame 2 windows are correct despite stale line-buffer data.

Source files
------------

// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel window generator:
//   - default grayscale sample width
//   - RGB field positions inside the 24-bit pixel word
//   - rgb2gray(): R + 2G + B, divided by 4 (keeps the top 8 bits of the 10-bit sum)
//   - window sample indices, k = 3*row + col, row 0 = top, col 0 = left
// ---------------------------------------------------------------------------
package sobel_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int GRAY_W    = 8;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   localparam int K_TL = 0;
   localparam int K_TC = 1;
   localparam int K_TR = 2;
   localparam int K_ML = 3;
   localparam int K_MC = 4;
   localparam int K_MR = 5;
   localparam int K_BL = 6;
   localparam int K_BC = 7;
   localparam int K_BR = 8;

   // A 10-bit sum cannot overflow: its largest value is 4*255 = 1020.
   function automatic logic [GRAY_W-1:0] rgb2gray(input logic [23:0] rgb);
      logic [9:0] sum;
      sum = {2'b00, rgb[R_HI:R_LO]}
          + {1'b0, rgb[G_HI:G_LO], 1'b0}
          + {2'b00, rgb[B_HI:B_LO]};
      return sum[9:2];
   endfunction

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image row of grayscale samples. Single address shared by read and write.
// The read is asynchronous, so the value seen in a cycle is the content from
// before that cycle's write (read-before-write at the same address).
// The array has no reset and can map onto distributed or block RAM.
// Ports:
//   clk    in   clock, write on posedge
//   we     in   write enable
//   addr   in   column address
//   wdata  in   sample to store
//   rdata  out  sample currently stored at addr
// ---------------------------------------------------------------------------
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int W     = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
// Converts an RGB pixel stream to grayscale, keeps the previous two rows in
// line buffers, and emits a registered 3x3 neighbourhood for every accepted
// pixel. Column and row position are tracked, and a pulse marks frame end.
//
// Handshake: pix_valid qualifies pix_in and sof. There is no ready signal, so
// every cycle with pix_valid=1 is an accepted pixel. win_valid qualifies
// win_out/win_x/win_y for exactly the cycle after the accepted pixel that
// completes an in-frame window.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active low
//   pix_in     in   RGB pixel, R=[23:16] G=[15:8] B=[7:0]
//   pix_valid  in   pix_in is valid this cycle
//   sof        in   start of frame: restart position at (0,0)
//   win_out    out  3x3 window, sample k at [PIX_W*k +: PIX_W], k8 = newest
//   win_valid  out  win_out holds a complete in-frame window
//   win_x      out  column of the window centre
//   win_y      out  row of the window centre
//   eof        out  one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = PIX_W_DEF,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [23:0]        pix_in,
   input  logic               pix_valid,
   input  logic               sof,
   output logic [9*PIX_W-1:0] win_out,
   output logic               win_valid,
   output logic [XW-1:0]      win_x,
   output logic [YW-1:0]      win_y,
   output logic               eof
);

   logic [XW-1:0]    col;
   logic [YW-1:0]    row;
   logic [XW-1:0]    cur_c;
   logic [YW-1:0]    cur_r;
   logic             last_c;
   logic             last_r;
   logic [PIX_W-1:0] gray;
   logic [PIX_W-1:0] lb0_q;
   logic [PIX_W-1:0] lb1_q;

   assign gray = PIX_W'(rgb2gray(pix_in));

   // sof overrides the counters so the marked pixel itself lands at (0,0).
   assign cur_c  = sof ? '0 : col;
   assign cur_r  = sof ? '0 : row;
   assign last_c = (cur_c == XW'(IMG_W - 1));
   assign last_r = (cur_r == YW'(IMG_H - 1));

   // lb0 holds the row above the current one, lb1 the row above that.
   // lb1 takes lb0's old value in the same cycle lb0 takes the new sample.
   line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(XW)) u_lb0 (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (cur_c),
      .wdata (gray),
      .rdata (lb0_q)
   );

   line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(XW)) u_lb1 (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (cur_c),
      .wdata (lb0_q),
      .rdata (lb1_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col       <= '0;
         row       <= '0;
         win_out   <= '0;
         win_valid <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
         eof       <= 1'b0;
      end else begin
         win_valid <= 1'b0;
         eof       <= 1'b0;
         if (pix_valid) begin
            // Shift every window row one column left, new column enters at right.
            win_out[PIX_W*K_TL +: PIX_W] <= win_out[PIX_W*K_TC +: PIX_W];
            win_out[PIX_W*K_TC +: PIX_W] <= win_out[PIX_W*K_TR +: PIX_W];
            win_out[PIX_W*K_TR +: PIX_W] <= lb1_q;
            win_out[PIX_W*K_ML +: PIX_W] <= win_out[PIX_W*K_MC +: PIX_W];
            win_out[PIX_W*K_MC +: PIX_W] <= win_out[PIX_W*K_MR +: PIX_W];
            win_out[PIX_W*K_MR +: PIX_W] <= lb0_q;
            win_out[PIX_W*K_BL +: PIX_W] <= win_out[PIX_W*K_BC +: PIX_W];
            win_out[PIX_W*K_BC +: PIX_W] <= win_out[PIX_W*K_BR +: PIX_W];
            win_out[PIX_W*K_BR +: PIX_W] <= gray;

            // Left columns are stale from the previous row until c reaches 2,
            // and the line buffers hold this frame's rows only from r = 2.
            win_valid <= (cur_c >= XW'(2)) && (cur_r >= YW'(2));
            win_x     <= cur_c - XW'(1);
            win_y     <= cur_r - YW'(1);
            eof       <= last_c && last_r;

            if (last_c) begin
               col <= '0;
               row <= last_r ? '0 : cur_r + YW'(1);
            end else begin
               col <= cur_c + XW'(1);
               row <= cur_r;
            end
         end else if (sof) begin
            col <= '0;
            row <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
// Directed bench for sobel_window_gen with a 4x4 image. A frame model keeps
// the gray value written at each position; every window it predicts is pushed
// to a queue when the pixel is driven and popped when win_valid appears.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [23:0]     pix_in    = '0;
   logic            pix_valid = 1'b0;
   logic            sof       = 1'b0;
   logic [9*PW-1:0] win_out;
   logic            win_valid;
   logic [XW-1:0]   win_x;
   logic [YW-1:0]   win_y;
   logic            eof;

   sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .sof       (sof),
      .win_out   (win_out),
      .win_valid (win_valid),
      .win_x     (win_x),
      .win_y     (win_y),
      .eof       (eof)
   );

   // ---------------- scoreboard / model ----------------
   int total = 0;
   int bad   = 0;
   int win_cnt = 0;
   int m_col = 0;
   int m_row = 0;
   logic [7:0]      img [H][W];
   logic [9*PW-1:0] exp_q [$];
   logic [XW+YW-1:0] exp_xy_q [$];
   logic [XW-1:0]   exp_x  = '0;
   logic [YW-1:0]   exp_y  = '0;
   logic [7:0]      exp_k8 = '0;

   task automatic chk(input string tag, input logic [9*PW-1:0] got, input logic [9*PW-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gray_ref(input logic [23:0] rgb);
      int s;
      s = int'(rgb[23:16]) + 2 * int'(rgb[15:8]) + int'(rgb[7:0]);
      return 8'(s / 4);
   endfunction

   // ---------------- driver ----------------
   // Drive one cycle, update the model, check all outputs 1 ns after the edge.
   task automatic send(input logic [23:0] rgb, input logic v, input logic s);
      int c;
      int r;
      logic ev;
      logic ee;
      logic [9*PW-1:0] w;
      pix_in = rgb;
      pix_valid = v;
      sof = s;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof = 1'b0;
      ev = 1'b0;
      ee = 1'b0;
      if (v) begin
         c = s ? 0 : m_col;
         r = s ? 0 : m_row;
         img[r][c] = gray_ref(rgb);
         ev = (c >= 2) && (r >= 2);
         ee = (c == W - 1) && (r == H - 1);
         exp_x = XW'(c - 1);
         exp_y = YW'(r - 1);
         exp_k8 = img[r][c];
         if (ev) begin
            w = {img[r][c],   img[r][c-1],   img[r][c-2],
                 img[r-1][c], img[r-1][c-1], img[r-1][c-2],
                 img[r-2][c], img[r-2][c-1], img[r-2][c-2]};
            exp_q.push_back(w);
            exp_xy_q.push_back({exp_x, exp_y});
         end
         if (c == W - 1) begin
            m_col = 0;
            m_row = (r == H - 1) ? 0 : r + 1;
         end else begin
            m_col = c + 1;
            m_row = r;
         end
      end else if (s) begin
         m_col = 0;
         m_row = 0;
      end
      chk("win_valid", win_valid, ev);
      chk("eof", eof, ee);
      chk("win_x", win_x, exp_x);
      chk("win_y", win_y, exp_y);
      chk("newest", win_out[8*PW +: PW], exp_k8);
      if (win_valid && exp_q.size() > 0) begin
         win_cnt++;
         chk("window", win_out, exp_q.pop_front());
         chk("win_xy", {win_x, win_y}, exp_xy_q.pop_front());
      end
   endtask

   // Ramp pixels i0..i1-1 of a frame, gray = base + 16r + c, R=G=B.
   task automatic send_frame(input int base, input bit gaps, input bit first_sof,
                             input int i0, input int i1);
      for (int i = i0; i < i1; i++) begin
         logic [7:0] v;
         v = 8'(base + 16 * (i / W) + (i % W));
         if (gaps) begin
            repeat ($urandom_range(0, 2)) send(24'h0, 1'b0, 1'b0);
         end
         send({v, v, v}, 1'b1, first_sof && (i == i0));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_win_out", win_out, '0);
      chk("rst_win_valid", win_valid, 1'b0);
      chk("rst_win_x", win_x, '0);
      chk("rst_win_y", win_y, '0);
      chk("rst_eof", eof, 1'b0);
      rst = 1'b1;
      send(24'h0, 1'b0, 1'b0);

      // gray conversion
      send(24'hFFFFFF, 1'b1, 1'b1);
      chk("gray_ffffff", win_out[8*PW +: PW], 8'hFF);
      send(24'h4080C0, 1'b1, 1'b0);
      chk("gray_4080c0", win_out[8*PW +: PW], 8'h80);
      send(24'h000003, 1'b1, 1'b0);
      chk("gray_000003", win_out[8*PW +: PW], 8'h00);

      // ramp frame, first window after the 11th pixel
      win_cnt = 0;
      send_frame(0, 1'b0, 1'b1, 0, 11);
      chk("first_win", win_out, 72'h22_21_20_12_11_10_02_01_00);
      chk("first_x", win_x, XW'(1));
      chk("first_y", win_y, YW'(1));
      send_frame(0, 1'b0, 1'b0, 11, 16);
      chk("ramp_count", win_cnt, 4);

      // same ramp with random idle gaps
      win_cnt = 0;
      send_frame(0, 1'b1, 1'b0, 0, 16);
      chk("gap_count", win_cnt, 4);

      // sof with the 6th pixel of a frame
      send_frame(8'h40, 1'b0, 1'b0, 0, 5);
      win_cnt = 0;
      send_frame(0, 1'b0, 1'b1, 0, 11);
      chk("sof_first_valid", win_valid, 1'b1);
      send_frame(0, 1'b0, 1'b0, 11, 16);
      chk("sof_count", win_cnt, 4);

      // asynchronous reset mid-frame, between clock edges
      send_frame(8'h08, 1'b0, 1'b0, 0, 11);
      chk("pre_rst_valid", win_valid, 1'b1);
      chk("sb_pre_reset", exp_q.size(), 0);
      #3;
      rst = 1'b0;
      #1;
      chk("async_win_out", win_out, '0);
      chk("async_win_valid", win_valid, 1'b0);
      chk("async_eof", eof, 1'b0);
      chk("async_win_x", win_x, '0);
      chk("async_win_y", win_y, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_col = 0;
      m_row = 0;
      exp_x = '0;
      exp_y = '0;
      exp_k8 = '0;
      win_cnt = 0;
      send_frame(8'h20, 1'b0, 1'b0, 0, 16);
      chk("post_rst_count", win_cnt, 4);

      // two back-to-back frames, frame 2 over stale line-buffer data
      win_cnt = 0;
      send_frame(8'h10, 1'b0, 1'b0, 0, 16);
      send_frame(8'h80, 1'b0, 1'b0, 0, 16);
      send(24'h0, 1'b0, 1'b0);
      chk("two_frame_count", win_cnt, 8);

      chk("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
